// File: rtl/fsm_unlock_pkg.sv
// Shared types and defaults for the unlock sequencer: the controller state set,
// the key-line width and the default key length, signature and retry budget.
package fsm_unlock_pkg;
    localparam int LINE_W = 2;
    localparam int KEY_LEN_DEF = 8;
    localparam logic [LINE_W-1:0] EXP_SIG_DEF = 2'b01;
    localparam int MAX_TRY_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEYING,
        ST_CHECK,
        ST_OPEN,
        ST_FAIL,
        ST_LOCKOUT
    } state_e;
endpackage

// File: rtl/fsm_key_store.sv
// Key register file: KEY_LEN entries of one key step each, one synchronous write
// port and one combinational read port; every entry clears on reset.
module fsm_key_store
    import fsm_unlock_pkg::*;
#(
    parameter int KEY_LEN = KEY_LEN_DEF
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       we_i,
    input  logic [$clog2(KEY_LEN)-1:0] waddr_i,
    input  logic [LINE_W-1:0]          wdata_i,
    input  logic [$clog2(KEY_LEN)-1:0] raddr_i,
    output logic [LINE_W-1:0]          rdata_o
);
    logic [LINE_W-1:0] key_q [KEY_LEN];

    genvar gi;
    generate
        for (gi = 0; gi < KEY_LEN; gi++) begin : g_entry
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    key_q[gi] <= '0;
                end else if (we_i && (int'(waddr_i) == gi)) begin
                    key_q[gi] <= wdata_i;
                end
            end
        end
    endgenerate

    assign rdata_o = key_q[raddr_i];
endmodule

// File: rtl/fsm_unlock_sequencer.sv
// Replays a stored key into a locked FSM, checks its signature, then either hands
// the FSM lines to a user requester or counts a failure towards a permanent lockout.
module fsm_unlock_sequencer
    import fsm_unlock_pkg::*;
#(
    parameter int                KEY_LEN = KEY_LEN_DEF,
    parameter logic [LINE_W-1:0] EXP_SIG = EXP_SIG_DEF,
    parameter int                MAX_TRY = MAX_TRY_DEF
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic                       relock_i,
    input  logic                       key_we_i,
    input  logic [$clog2(KEY_LEN)-1:0] key_addr_i,
    input  logic [LINE_W-1:0]          key_data_i,
    input  logic [LINE_W-1:0]          usr_line_i,
    input  logic                       usr_valid_i,
    input  logic [LINE_W-1:0]          fsm_out_i,
    output logic [LINE_W-1:0]          fsm_line_o,
    output logic                       usr_ready_o,
    output logic                       unlocked_o,
    output logic                       busy_o,
    output logic                       err_o
);
    localparam int AW = $clog2(KEY_LEN);
    localparam int CW = $clog2(MAX_TRY + 1);

    state_e            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     try_q, try_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [AW-1:0]     rd_addr;
    logic [LINE_W-1:0] key_rd;
    logic              key_wr_en;

    assign key_wr_en = key_we_i
                     && (state_q == ST_IDLE || state_q == ST_FAIL || state_q == ST_OPEN)
                     && (int'(key_addr_i) < KEY_LEN);

    // fsm_line is loaded with the step for the *next* state, so the read address
    // looks one step ahead while keying and at step 0 when a start is accepted.
    assign rd_addr = (state_q == ST_KEYING) ? idx_q + 1'b1 : '0;

    fsm_key_store #(.KEY_LEN(KEY_LEN)) u_key_store (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (key_wr_en),
        .waddr_i (key_addr_i),
        .wdata_i (key_data_i),
        .raddr_i (rd_addr),
        .rdata_o (key_rd)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        try_d   = try_q;
        line_d  = '0;
        case (state_q)
            ST_IDLE, ST_FAIL: begin
                if (start_i) begin
                    state_d = ST_KEYING;
                    idx_d   = '0;
                    line_d  = key_rd;
                end
            end
            ST_KEYING: begin
                if (int'(idx_q) == KEY_LEN - 1) begin
                    state_d = ST_CHECK;
                end else begin
                    idx_d  = idx_q + 1'b1;
                    line_d = key_rd;
                end
            end
            ST_CHECK: begin
                idx_d = '0;
                if (fsm_out_i == EXP_SIG) begin
                    state_d = ST_OPEN;
                    try_d   = '0;
                end else begin
                    if (int'(try_q) < MAX_TRY) begin
                        try_d = try_q + 1'b1;
                    end
                    state_d = (int'(try_d) >= MAX_TRY) ? ST_LOCKOUT : ST_FAIL;
                end
            end
            ST_OPEN: begin
                if (relock_i) begin
                    state_d = ST_IDLE;
                end else if (usr_valid_i) begin
                    line_d = usr_line_i;
                end
            end
            ST_LOCKOUT: begin
                state_d = ST_LOCKOUT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            try_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            try_q   <= try_d;
            line_q  <= line_d;
        end
    end

    assign fsm_line_o  = line_q;
    assign usr_ready_o = (state_q == ST_OPEN);
    assign unlocked_o  = (state_q == ST_OPEN);
    assign busy_o      = (state_q == ST_KEYING) || (state_q == ST_CHECK);
    assign err_o       = (state_q == ST_FAIL) || (state_q == ST_LOCKOUT);
endmodule

// File: tb/tb_fsm_unlock_sequencer.sv
// Directed-plus-random bench: a transaction-level model (key array, attempt count)
// predicts each replayed key sequence and each attempt's outcome.
module tb_fsm_unlock_sequencer;
    localparam int          KL  = 8;
    localparam logic [1:0]  EXP = 2'b01;
    localparam int          MT  = 3;

    logic       clk;
    logic       rst_n;
    logic       start, relock, key_we, usr_valid;
    logic [2:0] key_addr;
    logic [1:0] key_data, usr_line, fsm_out;
    logic [1:0] fsm_line;
    logic       usr_ready, unlocked, busy, err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] m_key [KL];
    int         m_tries;

    fsm_unlock_sequencer #(.KEY_LEN(KL), .EXP_SIG(EXP), .MAX_TRY(MT)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .relock_i    (relock),
        .key_we_i    (key_we),
        .key_addr_i  (key_addr),
        .key_data_i  (key_data),
        .usr_line_i  (usr_line),
        .usr_valid_i (usr_valid),
        .fsm_out_i   (fsm_out),
        .fsm_line_o  (fsm_line),
        .usr_ready_o (usr_ready),
        .unlocked_o  (unlocked),
        .busy_o      (busy),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [5:0] obs_now();
        return {fsm_line, usr_ready, unlocked, busy, err};
    endfunction

    function automatic logic [5:0] pk(logic [1:0] line, bit rdy, bit unl, bit bsy, bit er);
        return {line, rdy, unl, bsy, er};
    endfunction

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b {line,ready,unlocked,busy,err}", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        start = 0; relock = 0; key_we = 0; key_addr = 0; key_data = 0;
        usr_valid = 0; usr_line = 0;
    endtask

    // Random traffic on every input the sequencer must ignore while busy.
    task automatic noise();
        start     = 1'($urandom);
        relock    = 1'($urandom);
        key_we    = 1'b1;
        key_addr  = 3'($urandom);
        key_data  = 2'($urandom);
        usr_valid = 1'b1;
        usr_line  = 2'($urandom_range(1, 3));
    endtask

    task automatic write_key(input int a, input logic [1:0] d);
        @(negedge clk);
        quiet();
        key_we = 1; key_addr = 3'(a); key_data = d;
        m_key[a] = d;
    endtask

    // One full unlock attempt; sim_addr >= 0 also writes that address with the start.
    task automatic attempt(input logic [1:0] sig, input bit nz, input int sim_addr);
        logic [1:0] nd;
        @(negedge clk);
        quiet();
        start = 1; fsm_out = sig;
        if (sim_addr >= 0) begin
            nd = ~m_key[sim_addr];
            key_we = 1; key_addr = 3'(sim_addr); key_data = nd;
            m_key[sim_addr] = nd;
        end
        for (int i = 0; i < KL; i++) begin
            @(negedge clk);
            chk($sformatf("key_step%0d", i), obs_now(), pk(m_key[i], 0, 0, 1, 0));
            if (nz) noise(); else quiet();
        end
        @(negedge clk);
        chk("check_cycle", obs_now(), pk(2'b00, 0, 0, 1, 0));
        @(negedge clk);
        quiet();
        if (sig == EXP) begin
            m_tries = 0;
            chk("outcome_open", obs_now(), pk(2'b00, 1, 1, 0, 0));
        end else begin
            if (m_tries < MT) m_tries++;
            chk(m_tries >= MT ? "outcome_lockout" : "outcome_fail", obs_now(), pk(2'b00, 0, 0, 0, 1));
        end
    endtask

    // User traffic while open, including accepted key writes, then relock.
    task automatic open_phase(input int n);
        logic [1:0] exp_line;
        int         a;
        exp_line = 2'b00;
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                @(negedge clk);
                chk($sformatf("open_cyc%0d", k), obs_now(), pk(exp_line, 1, 1, 0, 0));
            end
            quiet();
            if (k == 0) begin
                usr_valid = 1; usr_line = 2'b10;
            end else begin
                usr_valid = 1'($urandom);
                usr_line  = 2'($urandom);
                start     = 1'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    a = $urandom_range(0, KL - 1);
                    key_we = 1; key_addr = 3'(a); key_data = 2'($urandom);
                    m_key[a] = key_data;
                end
            end
            exp_line = usr_valid ? usr_line : 2'b00;
        end
        @(negedge clk);
        chk("open_last", obs_now(), pk(exp_line, 1, 1, 0, 0));
        quiet();
        relock = 1; usr_valid = 1; usr_line = 2'b11;
        @(negedge clk);
        quiet();
        chk("relock_idle", obs_now(), pk(2'b00, 0, 0, 0, 0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 0;
        #1 chk("reset_async", obs_now(), pk(2'b00, 0, 0, 0, 0));
        quiet();
        for (int i = 0; i < KL; i++) m_key[i] = 2'b00;
        m_tries = 0;
        @(negedge clk);
        chk("reset_held", obs_now(), pk(2'b00, 0, 0, 0, 0));
        rst_n = 1;
    endtask

    initial begin
        logic [1:0] fixed_key [KL];
        fixed_key = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b00, 2'b11};
        rst_n = 0;
        quiet();
        fsm_out = 2'b00;
        for (int i = 0; i < KL; i++) m_key[i] = 2'b00;
        m_tries = 0;
        @(negedge clk);
        chk("reset_state", obs_now(), pk(2'b00, 0, 0, 0, 0));
        rst_n = 1;

        // Known key, clean attempt, signature match, user handoff.
        for (int i = 0; i < KL; i++) write_key(i, fixed_key[i]);
        attempt(EXP, 0, -1);
        open_phase(6);

        // Random key, noisy attempt (dropped writes, ignored start/relock/user).
        for (int i = 0; i < KL; i++) write_key(i, 2'($urandom));
        attempt(EXP, 1, -1);
        open_phase(5);

        // Start with a same-cycle write to address 3, then failures and a recovery.
        attempt(2'b11, 0, 3);
        write_key(5, 2'($urandom));
        attempt(2'b10, 1, -1);
        attempt(EXP, 1, -1);
        open_phase(3);

        // Three mismatches in a row end in lockout.
        attempt(2'b11, 1, -1);
        attempt(2'b11, 1, -1);
        attempt(2'b00, 0, -1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1; relock = 1; key_we = 1; key_addr = 3'(k); key_data = 2'b11;
            usr_valid = 1; usr_line = 2'b11;
            @(negedge clk);
            chk($sformatf("lockout_hold%0d", k), obs_now(), pk(2'b00, 0, 0, 0, 1));
        end
        quiet();

        // Reset clears lockout and the key store; a start replays all-zero steps.
        do_reset();
        attempt(2'b11, 0, -1);

        // Reset dropped at keying step 4, then a fresh attempt from step 0.
        for (int i = 0; i < KL; i++) write_key(i, 2'($urandom_range(1, 3)));
        @(negedge clk);
        quiet();
        start = 1;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            quiet();
            chk($sformatf("pre_reset_step%0d", i), obs_now(), pk(m_key[i], 0, 0, 1, 0));
        end
        do_reset();
        @(negedge clk);
        chk("post_reset_idle", obs_now(), pk(2'b00, 0, 0, 0, 0));
        for (int i = 0; i < KL; i++) write_key(i, fixed_key[KL - 1 - i]);
        attempt(EXP, 1, -1);
        open_phase(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fsm_unlock_sequencer.md
FSM_UNLOCK_SEQUENCER -- requirements
Module: fsm_unlock_sequencer

Interface
REQ-001 Parameter KEY_LEN, default 8: number of 2-bit key steps applied to the locked FSM.
REQ-002 Parameter EXP_SIG, default 2'b01: expected {overflw,outp} signature after keying.
REQ-003 Parameter MAX_TRY, default 3: failed unlock attempts allowed before lockout.
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle pulse; begins an unlock attempt.
REQ-007 relock  in  1  single-cycle pulse; returns the controller from OPEN to IDLE.
REQ-008 key_we  in  1  key store write enable.
REQ-009 key_addr  in  $clog2(KEY_LEN)  key store write address.
REQ-010 key_data  in  2  key step value, bit0=line1, bit1=line2.
REQ-011 usr_line  in  2  functional requester's {line2,line1}.
REQ-012 usr_valid  in  1  requester drives usr_line this cycle.
REQ-013 fsm_out  in  2  locked FSM {overflw,outp}.
REQ-014 fsm_line  out  2  registered drive to locked FSM {line2,line1}.
REQ-015 usr_ready  out  1  requester owns fsm_line.
REQ-016 unlocked  out  1  high in OPEN.
REQ-017 busy  out  1  high in KEYING or CHECK.
REQ-018 err  out  1  high in FAIL or LOCKOUT.

Function
REQ-019 States SHALL be IDLE, KEYING, CHECK, OPEN, FAIL and LOCKOUT.
REQ-020 IDLE: fsm_line=00; on start, go to KEYING with idx=0.
REQ-021 KEYING: fsm_line=key[idx] each cycle, idx+1 per cycle; after the idx=KEY_LEN-1 cycle, go to CHECK (KEY_LEN cycles in KEYING exactly).
REQ-022 CHECK: fsm_line=00 for one cycle; on the following edge compare fsm_out with EXP_SIG: match -> OPEN and attempt counter cleared; mismatch -> attempt counter +1, then FAIL, or LOCKOUT if the counter reaches MAX_TRY.
REQ-023 OPEN: usr_ready=1; fsm_line=usr_line when usr_valid, else 00, registered with 1-cycle latency; relock -> IDLE next cycle.
REQ-024 FAIL: fsm_line=00; start -> KEYING with idx=0 (retry).
REQ-025 LOCKOUT: terminal; fsm_line=00; start, relock and key_we ignored; exited only by reset.
REQ-026 start SHALL be ignored in KEYING, CHECK and OPEN; relock SHALL be ignored outside OPEN.
REQ-027 key_we SHALL write key[key_addr] only in IDLE, FAIL or OPEN; writes during busy SHALL be dropped.
REQ-028 key_addr >= KEY_LEN SHALL be ignored.
REQ-029 Simultaneous start and key_we in IDLE: the write takes effect; KEYING uses the new value if the same address is applied from the next cycle onward.
REQ-030 Attempt counter SHALL saturate at MAX_TRY and never wrap.
REQ-031 usr_ready SHALL be 0 in every state except OPEN; usr_line SHALL never reach fsm_line outside OPEN.

Reset
REQ-032 On reset low: state=IDLE, idx=0, attempt counter=0, fsm_line=00, usr_ready=0, unlocked=0, busy=0, err=0, all key entries=00.
REQ-033 Reset asserted mid-KEYING or in LOCKOUT SHALL abort immediately and asynchronously, with no further key steps emitted.

Structure
REQ-034 Package fsm_unlock_pkg SHALL hold the state enum, the line width constant (2) and the default KEY_LEN, EXP_SIG and MAX_TRY.
REQ-035 The key register file SHALL be a sub-module fsm_key_store (KEY_LEN x 2 bits, one write port, one async read port).

Verification
REQ-036 Load key 00,01,10,11,01,10,00,11 and pulse start -> fsm_line shows that sequence on 8 consecutive cycles, busy=1 throughout, then 00 for one CHECK cycle.
REQ-037 After REQ-036 with fsm_out=01 at the check edge -> unlocked=1 and usr_ready=1; usr_valid=1 with usr_line=10 -> fsm_line=10 one cycle later.
REQ-038 fsm_out=11 at the check edge, three times with a start between each -> FAIL, FAIL, then LOCKOUT with err=1; a later start or relock -> no change until reset.
REQ-039 key_we during KEYING to address 2 -> key[2] unchanged on the next attempt; start pulsed during KEYING -> sequence length stays 8.
REQ-040 Reset dropped at KEYING step 4 -> all outputs at reset values within the same cycle; a fresh start replays from step 0.
